// File: rtl/riscorvo_data_mem_resp.sv
// Single-ported data memory responder for the riscorvo core: captures one request,
// waits a fixed number of cycles, then returns a one-cycle completion strobe.
module riscorvo_data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic        read_write_i,
  input  logic [3:0]  mask_i,
  input  logic        stall_i,
  output logic        ready_o,
  output logic [31:0] read_data_o,
  output logic        err_o
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [33:0] BYTE_SPAN = 34'(DEPTH_WORDS) * 34'd4;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              rw_q;
  logic [3:0]        mask_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  word_idx;
  logic              accept;
  logic              mem_we;

  // Byte-lane merge of store data into the old word under the write mask.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // A wrapped subtraction shows up as addr below base, so both tests are needed.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] off);
    return (addr >= BASE_ADDR) && ({2'b00, off} < BYTE_SPAN);
  endfunction

  assign offset   = addr_q - BASE_ADDR;
  assign in_range = addr_in_range(addr_q, offset);
  assign word_idx = offset[IDX_W+1:2];
  assign accept   = (state_q == IDLE) && valid_i && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_i) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (wait_cnt_q == 4'd0) state_d = RESP;
      RESP: if (!stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
    end else if (accept) begin
      wait_cnt_q <= WAIT_LOAD;
    end else if ((state_q == WAIT) && (wait_cnt_q != 4'd0)) begin
      wait_cnt_q <= wait_cnt_q - 4'd1;
    end
  end

  // Request capture: later changes on the request inputs cannot disturb it.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rw_q    <= 1'b0;
      mask_q  <= 4'd0;
    end else if (accept) begin
      addr_q  <= addr_i;
      wdata_q <= write_data_i;
      rw_q    <= read_write_i;
      mask_q  <= mask_i;
    end
  end

  assign ready_o = (state_q == RESP) && !stall_i && !reset;
  assign mem_we  = ready_o && rw_q && in_range;

  // Backing store is deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[word_idx] <= merge_bytes(mem[word_idx], wdata_q, mask_q);
    end
  end

  always_comb begin
    read_data_o = 32'd0;
    err_o       = 1'b0;
    if (ready_o) begin
      err_o = !in_range;
      if (in_range && !rw_q) read_data_o = mem[word_idx];
    end
  end

endmodule

// File: doc/riscorvo_data_mem_resp.md
RISCORVO_DATA_MEM_RESP -- requirements
Module: riscorvo_data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing store (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, fixed wait states inserted before each response (0..15).
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid_i  input  1  request valid from core (valid_data_o side).
REQ-007 SHALL have port addr_i  input  32  byte address of request.
REQ-008 SHALL have port write_data_i  input  32  store data.
REQ-009 SHALL have port read_write_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port mask_i  input  4  byte enables for writes, bit n = byte lane n.
REQ-011 SHALL have port stall_i  input  1  extra backpressure; holds response while high.
REQ-012 SHALL have port ready_o  output  1  one-cycle completion strobe to core.
REQ-013 SHALL have port read_data_o  output  32  read data, valid only while ready_o high.
REQ-014 SHALL have port err_o  output  1  access fault, valid only while ready_o high.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-016 IDLE: valid_i high at cycle T SHALL capture addr_i, write_data_i, read_write_i, mask_i into request registers and go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-017 WAIT: down-counter loaded with WAIT_CYCLES-1 on acceptance; decrements each cycle; at 0 SHALL go to RESP.
REQ-018 RESP: ready_o SHALL be high only in a RESP cycle with stall_i low; that cycle SHALL return to IDLE; with stall_i high SHALL stay in RESP, ready_o low.
REQ-019 Unstalled latency: ready_o SHALL rise in cycle T+1+WAIT_CYCLES; each stall cycle adds one.
REQ-020 ready_o SHALL never be high two consecutive cycles; no request accepted in the RESP cycle; next acceptance earliest cycle after ready_o.
REQ-021 Request inputs changing or valid_i dropping after acceptance SHALL be ignored; captured request completes unchanged.
REQ-022 Word index SHALL be (addr - BASE_ADDR) >> 2, 32-bit unsigned subtract; addr[1:0] ignored (no misalignment support).
REQ-023 Address in range iff addr >= BASE_ADDR and index < DEPTH_WORDS; subtraction wrap-around SHALL count as out of range.
REQ-024 Out-of-range: ready_o strobe SHALL carry err_o=1, read_data_o=0, no write.
REQ-025 In-range write: in the ready_o cycle, byte lanes with mask bit 1 SHALL be updated, others unchanged; mask 4'b0000 SHALL complete with no change; read_data_o=0.
REQ-026 In-range read: read_data_o SHALL be the full stored word at the ready_o cycle, mask ignored; includes any write completed in an earlier cycle.
REQ-027 read_data_o and err_o SHALL be 0 whenever ready_o is low.

Reset
REQ-028 On reset: state IDLE, counter 0, ready_o=0, err_o=0, read_data_o=0, request registers 0.
REQ-029 Reset during WAIT or RESP SHALL abort the request with no write and no ready_o.
REQ-030 Backing store SHALL not be reset; contents before first write undefined, preserved across reset.
REQ-031 valid_i high in the cycle reset falls SHALL be accepted per REQ-016 in the first cycle with reset low.

Verification
REQ-032 WAIT_CYCLES=0: write 32'hDEADBEEF to 0x10, mask 4'b1111, then read 0x10 -> ready_o at T+1 each, read_data_o=32'hDEADBEEF, err_o=0.
REQ-033 WAIT_CYCLES=3: read request at cycle 5 -> ready_o only in cycle 9, single cycle.
REQ-034 Word 0x20 = 32'h11223344, write 32'hAABBCCDD mask 4'b0101 -> read returns 32'h11BB33DD.
REQ-035 DEPTH_WORDS=1024, BASE_ADDR=0: access 0x1000 -> ready_o with err_o=1, read_data_o=0; re-read 0xFFC unchanged.
REQ-036 stall_i high 4 cycles while in RESP -> ready_o delayed 4 cycles, then one-cycle strobe with correct data.
REQ-037 Reset asserted mid-WAIT of write to 0x8 -> no ready_o; read of 0x8 after reset returns pre-write value.
